// File: rtl/cmos_power_seq.sv
// Camera power-rail and reset sequencer for the CMOS sensor front end.
// Runs a timed PWDN/RESET power-up after system supplies are stable and a
// mirrored timed power-down when power is withdrawn or aborted.
`timescale 1ns/1ps
module cmos_power_seq #(
  parameter logic [23:0] T_PWUP   = 24'd250000,
  parameter logic [23:0] T_SETTLE = 24'd1000000,
  parameter logic [23:0] T_RST    = 24'd50000,
  parameter logic [23:0] T_OFF    = 24'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sys_ready,
  input  logic pwr_req,
  output logic cmos_pwdn,
  output logic cmos_rst_n,
  output logic cam_ready,
  output logic busy
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWUP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_DN_RST = 3'd4,
    S_DN_OFF = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pwdn_q, pwdn_d;
  logic        rst_n_q, rst_n_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        want_on;
  logic        timed;

  assign want_on = sys_ready && pwr_req;
  assign timed   = (state_q == S_PWUP) || (state_q == S_SETTLE) ||
                   (state_q == S_DN_RST) || (state_q == S_DN_OFF);

  // Next-state selection; an abort during power-up takes priority over dwell expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:    if (want_on) state_d = S_PWUP;
      S_PWUP: begin
        if (!want_on)                   state_d = S_DN_RST;
        else if (cnt_q == T_PWUP - 24'd1) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!want_on)                     state_d = S_DN_RST;
        else if (cnt_q == T_SETTLE - 24'd1) state_d = S_ON;
      end
      S_ON:     if (!want_on) state_d = S_DN_RST;
      S_DN_RST: if (cnt_q == T_RST - 24'd1) state_d = S_DN_OFF;
      S_DN_OFF: if (cnt_q == T_OFF - 24'd1) state_d = S_OFF;
      default:  state_d = S_OFF;
    endcase
  end

  // Dwell counter: cleared on any state change, counts only in timed states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (timed)         cnt_d = cnt_q + 24'd1;
  end

  // Output decode from the next state so pins register on the same edge as the state.
  always_comb begin
    pwdn_d  = 1'b1;
    rst_n_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      S_OFF:    begin pwdn_d = 1'b1; rst_n_d = 1'b0; ready_d = 1'b0; busy_d = 1'b0; end
      S_PWUP:   begin pwdn_d = 1'b0; rst_n_d = 1'b0; ready_d = 1'b0; busy_d = 1'b1; end
      S_SETTLE: begin pwdn_d = 1'b0; rst_n_d = 1'b1; ready_d = 1'b0; busy_d = 1'b1; end
      S_ON:     begin pwdn_d = 1'b0; rst_n_d = 1'b1; ready_d = 1'b1; busy_d = 1'b0; end
      S_DN_RST: begin pwdn_d = 1'b0; rst_n_d = 1'b0; ready_d = 1'b0; busy_d = 1'b1; end
      S_DN_OFF: begin pwdn_d = 1'b1; rst_n_d = 1'b0; ready_d = 1'b0; busy_d = 1'b1; end
      default:  begin pwdn_d = 1'b1; rst_n_d = 1'b0; ready_d = 1'b0; busy_d = 1'b0; end
    endcase
  end

  // State, dwell counter and registered pins; hard reset forces OFF immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwdn_q  <= 1'b1;
      rst_n_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwdn_q  <= pwdn_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign cmos_pwdn  = pwdn_q;
  assign cmos_rst_n = rst_n_q;
  assign cam_ready  = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cmos_power_seq.sv
// Bench for cmos_power_seq with short timing parameters (4/6/3/5).
`timescale 1ns/1ps
module tb_cmos_power_seq;

  localparam logic [3:0] O_OFF    = 4'b1000; // {pwdn, rst_n, ready, busy}
  localparam logic [3:0] O_PWUP   = 4'b0001;
  localparam logic [3:0] O_SETTLE = 4'b0101;
  localparam logic [3:0] O_ON     = 4'b0110;
  localparam logic [3:0] O_DNRST  = 4'b0001;
  localparam logic [3:0] O_DNOFF  = 4'b1001;

  typedef struct {
    bit          sys;
    bit          pwr;
    int unsigned n;
    logic [3:0]  exp;
    string       tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sys_ready = 1'b0;
  logic pwr_req = 1'b0;
  logic cmos_pwdn, cmos_rst_n, cam_ready, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stepno = 0;
  logic [3:0]  sb[$];
  vec_t        tbl[$];
  logic        prev_pwdn, prev_rstn;

  cmos_power_seq #(
    .T_PWUP  (24'd4),
    .T_SETTLE(24'd6),
    .T_RST   (24'd3),
    .T_OFF   (24'd5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sys_ready (sys_ready),
    .pwr_req   (pwr_req),
    .cmos_pwdn (cmos_pwdn),
    .cmos_rst_n(cmos_rst_n),
    .cam_ready (cam_ready),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check_now(input logic [3:0] want, input string tag);
    logic [3:0] got;
    got = {cmos_pwdn, cmos_rst_n, cam_ready, busy};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %b want %b", tag, stepno, got, want);
    end
  endtask

  // Drive inputs at negedge, queue the output expected after the next edge,
  // then compare at the following negedge.
  task automatic step(input bit s, input bit p, input logic [3:0] e, input string tag);
    logic [3:0] want;
    sys_ready = s;
    pwr_req   = p;
    sb.push_back(e);
    prev_pwdn = cmos_pwdn;
    prev_rstn = cmos_rst_n;
    @(posedge clk);
    @(negedge clk);
    stepno++;
    want = sb.pop_front();
    check_now(want, tag);
    checks++;
    if ((cmos_pwdn !== prev_pwdn) && (cmos_rst_n !== prev_rstn)) begin
      errors++;
      $display("FAIL %s pins both changed step %0d got pwdn=%b rst_n=%b want one change", tag, stepno, cmos_pwdn, cmos_rst_n);
    end
  endtask

  task automatic seg(input bit s, input bit p, input int unsigned n, input logic [3:0] e, input string tag);
    for (int unsigned i = 0; i < n; i++) step(s, p, e, tag);
  endtask

  task automatic add(input bit s, input bit p, input int unsigned n, input logic [3:0] e, input string tag);
    vec_t v;
    v.sys = s; v.pwr = p; v.n = n; v.exp = e; v.tag = tag;
    tbl.push_back(v);
  endtask

  initial begin
    // idle, then test 1: start, exact dwells
    add(0, 0,  3, O_OFF,    "idle");
    add(1, 1,  4, O_PWUP,   "t1_pwup");
    add(1, 1,  6, O_SETTLE, "t1_settle");
    add(1, 1,  3, O_ON,     "t1_on");
    // test 2: graceful stop
    add(1, 0,  3, O_DNRST,  "t2_dnrst");
    add(1, 0,  5, O_DNOFF,  "t2_dnoff");
    add(1, 0,  3, O_OFF,    "t2_off");
    // test 3: sys_ready glitch in SETTLE, then automatic restart
    add(1, 1,  4, O_PWUP,   "t3_pwup");
    add(1, 1,  2, O_SETTLE, "t3_settle");
    add(0, 1,  1, O_DNRST,  "t3_abort");
    add(1, 1,  2, O_DNRST,  "t3_dnrst");
    add(1, 1,  5, O_DNOFF,  "t3_dnoff");
    add(1, 1,  1, O_OFF,    "t3_off1");
    add(1, 1,  4, O_PWUP,   "t3_repwup");
    add(1, 1,  6, O_SETTLE, "t3_resettle");
    add(1, 1,  2, O_ON,     "t3_on");
    // test 4: pwr_req back one cycle into DN_RST
    add(1, 0,  1, O_DNRST,  "t4_drop");
    add(1, 1,  2, O_DNRST,  "t4_dnrst");
    add(1, 1,  5, O_DNOFF,  "t4_dnoff");
    add(1, 1,  1, O_OFF,    "t4_off1");
    add(1, 1,  4, O_PWUP,   "t4_pwup");
    add(1, 1,  6, O_SETTLE, "t4_settle");
    add(1, 1,  2, O_ON,     "t4_on");
    // abort by pwr_req during PWUP
    add(1, 0,  3, O_DNRST,  "ab_dnrst");
    add(1, 0,  5, O_DNOFF,  "ab_dnoff");
    add(1, 0,  1, O_OFF,    "ab_off");
    add(1, 1,  2, O_PWUP,   "ab_pwup");
    add(1, 0,  3, O_DNRST,  "ab2_dnrst");
    add(1, 0,  5, O_DNOFF,  "ab2_dnoff");
    add(1, 0,  2, O_OFF,    "ab2_off");

    // reset state, held asynchronously
    rst = 1'b1;
    #25;
    check_now(O_OFF, "reset");
    @(negedge clk);
    rst = 1'b0;
    prev_pwdn = cmos_pwdn;
    prev_rstn = cmos_rst_n;

    foreach (tbl[i]) seg(tbl[i].sys, tbl[i].pwr, tbl[i].n, tbl[i].exp, tbl[i].tag);

    // test 5: async reset while ON, then restart with test-1 timing
    seg(1, 1, 4, O_PWUP,   "t5_pwup");
    seg(1, 1, 6, O_SETTLE, "t5_settle");
    seg(1, 1, 2, O_ON,     "t5_on");
    #3;
    rst = 1'b1;
    #1;
    check_now(O_OFF, "t5_async_rst");
    @(posedge clk);
    @(negedge clk);
    check_now(O_OFF, "t5_rst_held");
    rst = 1'b0;
    seg(1, 1, 4, O_PWUP,   "t5_repwup");
    seg(1, 1, 6, O_SETTLE, "t5_resettle");
    seg(1, 1, 2, O_ON,     "t5_reon");
    seg(1, 0, 3, O_DNRST,  "t5_dnrst");
    seg(1, 0, 5, O_DNOFF,  "t5_dnoff");
    seg(1, 0, 1, O_OFF,    "t5_off");

    // test 6: pwr_req without sys_ready stays OFF
    seg(0, 1, 100, O_OFF,  "t6_wait");
    seg(1, 1, 4, O_PWUP,   "t6_pwup");
    seg(1, 1, 6, O_SETTLE, "t6_settle");
    seg(1, 1, 1, O_ON,     "t6_on");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_power_seq.md
# cmos_power_seq

Camera power-rail and reset sequencer for the CMOS sensor front end. Waits for the system power-on delay to complete, then drives the sensor power-down and reset pins through a timed power-up sequence. Raises `cam_ready` to release the SCCB configuration block. When power is withdrawn, it runs the mirrored timed power-down sequence, so it acts as the far end of the power-on-delay handshake.

## Interface
Parameters:
- `T_PWUP`, 24'd250000: cycles from PWDN release to reset release (5 ms @ 50 MHz).
- `T_SETTLE`, 24'd1000000: cycles from reset release to `cam_ready` (20 ms).
- `T_RST`, 24'd50000: cycles the reset is held before PWDN on shutdown (1 ms).
- `T_OFF`, 24'd500000: minimum off time before a restart is allowed (10 ms).
- All timing parameters are ≥ 2 and ≤ 2^24−1.

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `sys_ready`, in, 1: level from the system init delay; 1 means supplies are stable.
- `pwr_req`, in, 1: level; 1 requests the camera on, 0 requests it off.
- `cmos_pwdn`, out, 1: sensor power-down pin, active high.
- `cmos_rst_n`, out, 1: sensor reset pin, active low.
- `cam_ready`, out, 1: 1 while the sensor is fully powered and out of reset.
- `busy`, out, 1: 1 in any transitional state.

## Operation
- One-hot or encoded FSM with states OFF, PWUP, SETTLE, ON, DN_RST, DN_OFF.
- A 24-bit dwell counter is cleared on every state change. It increments while a timed state is active. A timed state exits when the counter reaches T−1, giving a dwell of exactly T cycles.
- Outputs per state, given as (`cmos_pwdn`, `cmos_rst_n`, `cam_ready`, `busy`):
  - OFF: (1, 0, 0, 0)
  - PWUP: (0, 0, 0, 1)
  - SETTLE: (0, 1, 0, 1)
  - ON: (0, 1, 1, 0)
  - DN_RST: (0, 0, 0, 1)
  - DN_OFF: (1, 0, 0, 1)
- Transitions:
  - OFF → PWUP when `sys_ready && pwr_req`.
  - PWUP → SETTLE after T_PWUP.
  - SETTLE → ON after T_SETTLE.
  - ON → DN_RST when `!pwr_req || !sys_ready`.
  - DN_RST → DN_OFF after T_RST.
  - DN_OFF → OFF after T_OFF.
- Abort: if `!pwr_req || !sys_ready` during PWUP or SETTLE, the next state is DN_RST. Reset is asserted immediately and the full shutdown sequence runs.
- Restart during shutdown: `pwr_req` rising in DN_RST or DN_OFF is ignored until OFF is reached. The OFF → PWUP condition is then evaluated on the first OFF cycle, with no extra dwell in OFF.
- `cmos_pwdn` and `cmos_rst_n` never both change on the same edge. Every sequence enforces reset-before-PWDN on the way down and PWDN-before-reset on the way up.

## Timing
- All outputs are registered and update on the same edge as the state register. There are no combinational paths from inputs to outputs.
- Reset (`rst` = 1, asynchronous) forces state OFF, counter 0, `cmos_pwdn`=1, `cmos_rst_n`=0, `cam_ready`=0, `busy`=0.
- Reset asserted mid-sequence (including in ON) drops the pins to the OFF values immediately, without the graceful shutdown. This is intentional: a hard reset means the system is losing supplies.
- Start latency: if the start condition is sampled high at edge k, `cmos_pwdn` falls at edge k+1.
  - `cmos_rst_n` rises at k+1+T_PWUP.
  - `cam_ready` rises at k+1+T_PWUP+T_SETTLE.
- Stop latency: if `pwr_req` is sampled low in ON at edge k, `cam_ready` and `cmos_rst_n` fall at k+1.
  - `cmos_pwdn` rises at k+1+T_RST.
  - The state returns to OFF (`busy` falls) at k+1+T_RST+T_OFF.
- The inputs are synchronous to `clk`; no synchronizers are inside this block.

## Test plan
Use the bench parameters T_PWUP=4, T_SETTLE=6, T_RST=3, T_OFF=5.
1. Reset, then `sys_ready`=1 and `pwr_req`=1 from edge 10 → `cmos_pwdn` falls at edge 11, `cmos_rst_n` rises at 15, `cam_ready` rises at 21. `busy` is high for edges 11–20.
2. From ON, drop `pwr_req` at edge k → `cam_ready` and `cmos_rst_n` are 0 at k+1, `cmos_pwdn`=1 at k+4, and `busy`=0 at k+9.
3. Drop `sys_ready` for 1 cycle during SETTLE → enter DN_RST next edge, `cmos_rst_n`=0, and `cam_ready` never asserts. The full 3+5 shutdown runs, then an automatic restart happens because `pwr_req` is still 1 and `sys_ready` has returned.
4. Re-assert `pwr_req` 1 cycle into DN_RST → the shutdown completes unchanged (8 cycles). PWUP is entered on the edge after OFF is reached, and the pins never glitch.
5. Assert `rst` asynchronously between edges while in ON → the outputs immediately read (1, 0, 0, 0). After `rst` release with the inputs still high, the sequence restarts per test 1 timing.
6. `pwr_req`=1 with `sys_ready`=0 for 100 cycles → the block remains in OFF with outputs (1, 0, 0, 0). Raising `sys_ready` starts the sequence one edge later.
